// File: rtl/cmd_responder.sv
// cmd_responder: runs one-cycle command pulses against a DEPTH-word register file at an internal pointer.
// write/inc/dec finish on the accepting edge, read returns one edge later, clear holds busy for DEPTH cycles; pulses while busy are dropped and flagged. Option macro: PTR_SATURATE_EN.
module cmd_responder #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              nrst,
   input  logic              clear,
   input  logic              read,
   input  logic              write,
   input  logic              enable_increment,
   input  logic              enable_decrement,
   input  logic [1:0]        output_select,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata,
   output logic              rvalid,
   output logic              busy,
   output logic [ADDR_W-1:0] ptr,
   output logic              cmd_err,
   output logic [DATA_W-1:0] disp
);

`ifdef PTR_SATURATE_EN
   localparam bit SATURATE = 1'b1;
`else
   localparam bit SATURATE = 1'b0;
`endif

   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

   typedef enum logic [1:0] {IDLE, READ, CLEAR} state_t;

   state_t            state, state_nxt;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [ADDR_W-1:0] cnt;
   logic [ADDR_W-1:0] ptr_inc, ptr_dec;
   logic              cmd_any;
   logic              do_clear, do_write, do_inc, do_dec;
   logic              read_done, clear_step, clear_done, set_err;

   assign cmd_any = clear | read | write | enable_increment | enable_decrement;

   always_comb begin
      ptr_inc = (ptr == LAST) ? '0 : ptr + 1'b1;
      ptr_dec = (ptr == '0) ? LAST : ptr - 1'b1;
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      do_clear   = 1'b0;
      do_write   = 1'b0;
      do_inc     = 1'b0;
      do_dec     = 1'b0;
      read_done  = 1'b0;
      clear_step = 1'b0;
      clear_done = 1'b0;
      set_err    = 1'b0;
      case (state)
         IDLE: begin
            if (clear) begin
               do_clear  = 1'b1;
               state_nxt = CLEAR;
            end else if (write) begin
               do_write = 1'b1;
               set_err  = read | enable_increment | enable_decrement;
            end else if (read) begin
               state_nxt = READ;
               set_err   = enable_increment | enable_decrement;
            end else if (enable_increment && enable_decrement) begin
               set_err = 1'b1;
            end else if (enable_increment) begin
               if (SATURATE && ptr == LAST) set_err = 1'b1;
               else                         do_inc  = 1'b1;
            end else if (enable_decrement) begin
               if (SATURATE && ptr == '0) set_err = 1'b1;
               else                       do_dec  = 1'b1;
            end
         end
         READ: begin
            read_done = 1'b1;
            set_err   = cmd_any;
            state_nxt = IDLE;
         end
         CLEAR: begin
            clear_step = 1'b1;
            set_err    = cmd_any;
            if (cnt == LAST) begin
               clear_done = 1'b1;
               state_nxt  = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         ptr     <= '0;
         rdata   <= '0;
         rvalid  <= 1'b0;
         busy    <= 1'b0;
         cmd_err <= 1'b0;
         cnt     <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         rvalid <= read_done;
         busy   <= (state_nxt != IDLE);

         // An accepted clear wins over any flag raised on the same edge
         if (do_clear)     cmd_err <= 1'b0;
         else if (set_err) cmd_err <= 1'b1;

         if (do_clear || clear_done) cnt <= '0;
         else if (clear_step)        cnt <= cnt + 1'b1;

         if (do_write)   mem[ptr] <= wdata;
         if (clear_step) mem[cnt] <= '0;

         if (clear_done)     rdata <= '0;
         else if (read_done) rdata <= mem[ptr];

         if (clear_done)  ptr <= '0;
         else if (do_inc) ptr <= ptr_inc;
         else if (do_dec) ptr <= ptr_dec;
      end
   end

   always_comb begin
      disp = '0;
      case (output_select)
         2'b00:   disp = DATA_W'(ptr);
         2'b01:   disp = rdata;
         2'b10:   disp = mem[ptr];
         default: disp[2:0] = {cmd_err, busy, rvalid};
      endcase
   end

endmodule

// File: tb/tb_cmd_responder.sv
// tb_cmd_responder: vector table plus hand sequences for cmd_responder; read data checked through a scoreboard queue.
module tb_cmd_responder;

`ifdef PTR_SATURATE_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       nrst;
   logic       clear, read, write, enable_increment, enable_decrement;
   logic [1:0] output_select;
   logic [7:0] wdata, rdata, disp;
   logic       rvalid, busy, cmd_err;
   logic [3:0] ptr;

   int n_cmp = 0;
   int n_bad = 0;
   int sb[$];

   cmd_responder #(.DATA_W(8), .DEPTH(16)) dut (
      .clk(clk), .nrst(nrst), .clear(clear), .read(read), .write(write),
      .enable_increment(enable_increment), .enable_decrement(enable_decrement),
      .output_select(output_select), .wdata(wdata), .rdata(rdata), .rvalid(rvalid),
      .busy(busy), .ptr(ptr), .cmd_err(cmd_err), .disp(disp)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       c, r, w, i, d;
      logic [7:0] wd;
      logic [1:0] sel;
      logic [3:0] e_ptr;
      logic       e_busy, e_rv, e_err;
      logic [7:0] e_disp;
      logic [7:0] e_rd;
   } vec_t;

   vec_t vecs[15];

   function automatic vec_t mk(input int c, r, w, i, d, wd, sel, ep, eb, ev, ee, ed, erd);
      vec_t v;
      v.c = c[0]; v.r = r[0]; v.w = w[0]; v.i = i[0]; v.d = d[0];
      v.wd = wd[7:0]; v.sel = sel[1:0]; v.e_ptr = ep[3:0];
      v.e_busy = eb[0]; v.e_rv = ev[0]; v.e_err = ee[0];
      v.e_disp = ed[7:0]; v.e_rd = erd[7:0];
      return v;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Called at a falling edge; inputs are seen by the next rising edge, returns at the following falling edge
   task automatic step(input int c, r, w, i, d, wd, sel);
      clear = c[0]; read = r[0]; write = w[0];
      enable_increment = i[0]; enable_decrement = d[0];
      wdata = wd[7:0]; output_select = sel[1:0];
      @(negedge clk);
      clear = 1'b0; read = 1'b0; write = 1'b0;
      enable_increment = 1'b0; enable_decrement = 1'b0;
   endtask

   task automatic peek(input int sel, input string name, input int exp);
      output_select = sel[1:0];
      #1;
      check(name, int'(disp), exp);
   endtask

   task automatic clear_wait();
      int n = 0;
      step(1, 0, 0, 0, 0, 0, 3);
      while (busy && n < 40) begin
         step(0, 0, 0, 0, 0, 0, 3);
         n++;
      end
      check("clear_done_busy", int'(busy), 0);
   endtask

   always @(negedge clk) begin
      if (nrst && rvalid) begin
         if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL sb_unexpected_rvalid: got rdata 0x%0h, expected no rvalid", rdata);
         end else begin
            check("sb_rdata", int'(rdata), sb.pop_front());
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int mp;
      int n_busy;

      vecs[0]  = mk(0,0,0,1,0, 'h00,0, 1,0,0,0,'h01,0);
      vecs[1]  = mk(0,0,0,1,0, 'h00,0, 2,0,0,0,'h02,0);
      vecs[2]  = mk(0,0,0,1,0, 'h00,0, 3,0,0,0,'h03,0);
      vecs[3]  = mk(0,0,1,0,0, 'hA5,2, 3,0,0,0,'hA5,0);
      vecs[4]  = mk(0,1,0,0,0, 'h00,1, 3,1,0,0,'h00,'hA5);
      vecs[5]  = mk(0,0,0,0,0, 'h00,1, 3,0,1,0,'hA5,0);
      vecs[6]  = mk(0,0,0,0,0, 'h00,3, 3,0,0,0,'h00,0);
      vecs[7]  = mk(0,0,0,1,0, 'h00,2, 4,0,0,0,'h00,0);
      vecs[8]  = mk(0,0,1,0,0, 'h5A,2, 4,0,0,0,'h5A,0);
      vecs[9]  = mk(0,1,0,0,0, 'h00,3, 4,1,0,0,'h02,'h5A);
      vecs[10] = mk(0,0,0,0,0, 'h00,3, 4,0,1,0,'h01,0);
      vecs[11] = mk(0,0,0,0,1, 'h00,1, 3,0,0,0,'h5A,0);
      vecs[12] = mk(0,0,0,0,0, 'h00,2, 3,0,0,0,'hA5,0);
      vecs[13] = mk(0,1,0,0,0, 'h00,1, 3,1,0,0,'h5A,'hA5);
      vecs[14] = mk(0,0,0,0,0, 'h00,1, 3,0,1,0,'hA5,0);

      nrst = 1'b0;
      clear = 1'b0; read = 1'b0; write = 1'b0;
      enable_increment = 1'b0; enable_decrement = 1'b0;
      output_select = 2'b00; wdata = 8'h00;
      repeat (3) @(negedge clk);
      check("rst_ptr", int'(ptr), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_rvalid", int'(rvalid), 0);
      check("rst_err", int'(cmd_err), 0);
      check("rst_rdata", int'(rdata), 0);
      check("rst_disp", int'(disp), 0);
      nrst = 1'b1;
      @(negedge clk);

      for (int k = 0; k < 15; k++) begin
         if (vecs[k].r) sb.push_back(int'(vecs[k].e_rd));
         step(vecs[k].c, vecs[k].r, vecs[k].w, vecs[k].i, vecs[k].d, vecs[k].wd, vecs[k].sel);
         check($sformatf("vec%0d_ptr", k), int'(ptr), int'(vecs[k].e_ptr));
         check($sformatf("vec%0d_busy", k), int'(busy), int'(vecs[k].e_busy));
         check($sformatf("vec%0d_rvalid", k), int'(rvalid), int'(vecs[k].e_rv));
         check($sformatf("vec%0d_err", k), int'(cmd_err), int'(vecs[k].e_err));
         check($sformatf("vec%0d_disp", k), int'(disp), int'(vecs[k].e_disp));
      end

      // pointer boundaries
      for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 1, 0, 0);
      check("ptr_at_zero", int'(ptr), 0);
      step(0, 0, 0, 0, 1, 0, 0);
      check("dec_at_zero_ptr", int'(ptr), SAT ? 0 : 15);
      check("dec_at_zero_err", int'(cmd_err), SAT ? 1 : 0);
      mp = SAT ? 0 : 15;
      for (int k = mp; k < 15; k++) step(0, 0, 0, 1, 0, 0, 0);
      check("ptr_at_top", int'(ptr), 15);
      step(0, 0, 0, 1, 0, 0, 0);
      check("inc_at_top_ptr", int'(ptr), SAT ? 15 : 0);
      check("inc_at_top_err", int'(cmd_err), SAT ? 1 : 0);

      // fill with FF, read the last word, then clear everything
      clear_wait();
      check("clear_ptr0", int'(ptr), 0);
      check("clear_err0", int'(cmd_err), 0);
      for (int k = 0; k < 16; k++) begin
         step(0, 0, 1, 0, 0, 'hFF, 2);
         if (k < 15) step(0, 0, 0, 1, 0, 0, 2);
      end
      check("fill_disp", int'(disp), 'hFF);
      sb.push_back('hFF);
      step(0, 1, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 0, 1);
      check("read_ff_disp", int'(disp), 'hFF);
      step(1, 0, 0, 0, 0, 0, 3);
      n_busy = busy ? 1 : 0;
      for (int k = 0; k < 40; k++) begin
         step(0, 0, 0, 0, 0, 0, 3);
         if (!busy) break;
         n_busy++;
      end
      check("clear_busy_cycles", n_busy, 16);
      check("after_clear_ptr", int'(ptr), 0);
      check("after_clear_err", int'(cmd_err), 0);
      peek(1, "after_clear_rdata", 0);
      for (int k = 0; k < 16; k++) begin
         peek(2, $sformatf("mem%0d_zero", k), 0);
         if (k < 15) step(0, 0, 0, 1, 0, 0, 2);
      end

      // read while clearing is refused and flagged; next clear drops the flag
      step(1, 0, 0, 0, 0, 0, 3);
      check("clr_busy_disp", int'(disp), 'h02);
      step(0, 0, 0, 0, 0, 0, 3);
      step(0, 1, 0, 0, 0, 0, 3);
      check("read_in_clear_disp", int'(disp), 'h06);
      for (int k = 0; k < 40 && busy; k++) step(0, 0, 0, 0, 0, 0, 3);
      check("read_in_clear_busy_end", int'(busy), 0);
      check("read_in_clear_err_sticky", int'(cmd_err), 1);
      clear_wait();
      check("reclear_err", int'(cmd_err), 0);

      // simultaneous commands
      step(0, 1, 1, 0, 0, 'h3C, 2);
      check("wr_rd_busy", int'(busy), 0);
      check("wr_rd_err", int'(cmd_err), 1);
      check("wr_rd_disp", int'(disp), 'h3C);
      step(0, 0, 0, 0, 0, 0, 2);
      check("wr_rd_no_rvalid", int'(rvalid), 0);
      clear_wait();
      step(0, 0, 0, 1, 1, 0, 0);
      check("inc_dec_ptr", int'(ptr), 0);
      check("inc_dec_err", int'(cmd_err), 1);

      // reset in the middle of a clear
      for (int k = 0; k < 9; k++) step(0, 0, 0, 1, 0, 0, 2);
      step(0, 0, 1, 0, 0, 'h77, 2);
      check("w9_disp", int'(disp), 'h77);
      step(1, 0, 0, 0, 0, 0, 3);
      step(0, 0, 0, 0, 0, 0, 3);
      step(0, 1, 0, 0, 0, 0, 3);
      step(0, 0, 0, 0, 0, 0, 3);
      check("pre_rst_disp", int'(disp), 'h06);
      #2 nrst = 1'b0;
      #1;
      check("mid_rst_ptr", int'(ptr), 0);
      check("mid_rst_busy", int'(busy), 0);
      check("mid_rst_err", int'(cmd_err), 0);
      check("mid_rst_disp_status", int'(disp), 0);
      peek(0, "mid_rst_disp_ptr", 0);
      @(negedge clk);
      nrst = 1'b1;
      peek(2, "post_rst_mem0", 0);
      peek(1, "post_rst_rdata", 0);
      for (int k = 0; k < 9; k++) step(0, 0, 0, 1, 0, 0, 2);
      check("post_rst_ptr9", int'(ptr), 9);
      check("post_rst_mem9", int'(disp), 0);

      check("sb_empty", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
